// File: rtl/bf16_addsub_sched_44.sv
// bf16_addsub_sched_44: round-robin front end that shares one BF16 add/sub core
// between N_REQ requesters. Issue is limited by credits so the response FIFO
// can never overflow. A tag pipeline follows the core so that each result
// returns with its owner's id, and results retire in issue order.
module bf16_addsub_sched_44 #(
  parameter int N_REQ      = 4,
  parameter int ID_W       = 2,
  parameter int CORE_LAT   = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk_44,
  input  logic                 rst_44,
  input  logic [N_REQ-1:0]     req_valid_44,
  input  logic [16*N_REQ-1:0]  req_a_44,
  input  logic [16*N_REQ-1:0]  req_b_44,
  input  logic [N_REQ-1:0]     req_sub_44,
  output logic [N_REQ-1:0]     req_ready_44,
  output logic                 core_rst_n_44,
  output logic                 core_valid_in_44,
  output logic [15:0]          core_a_44,
  output logic [15:0]          core_b_44,
  output logic                 core_sub_44,
  input  logic [15:0]          core_result_44,
  input  logic                 core_valid_out_44,
  output logic                 rsp_valid_44,
  input  logic                 rsp_ready_44,
  output logic [15:0]          rsp_data_44,
  output logic [ID_W-1:0]      rsp_id_44,
  output logic [2:0]           inflight_44,
  output logic                 err_44
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

  // issue side state
  logic [ID_W-1:0]              rr_ptr_q, rr_ptr_d;
  logic                         core_valid_q, core_valid_d;
  logic [15:0]                  core_a_q, core_a_d, core_b_q, core_b_d;
  logic                         core_sub_q, core_sub_d;
  logic [CORE_LAT:0]            tag_v_q, tag_v_d;
  logic [CORE_LAT:0][ID_W-1:0]  tag_id_q, tag_id_d;
  logic [2:0]                   inflight_q, inflight_d;
  logic                         err_q, err_d;

  // response FIFO state
  logic [15:0]                  mem_data_q [FIFO_DEPTH];
  logic [ID_W-1:0]              mem_id_q   [FIFO_DEPTH];
  logic [AW-1:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic                         rsp_valid_q, rsp_valid_d;
  logic [15:0]                  rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]              rsp_id_q, rsp_id_d;

  logic                         can_issue_s, any_valid_s, hit_s, hs_s, push_s, pop_s;
  logic [ID_W-1:0]              grant_idx_s, cand_s;
  logic [N_REQ-1:0]             grant_s;
  logic [15:0]                  sel_a_s, sel_b_s;
  logic                         sel_sub_s;

  // Credits come from registered counts only, so a pop frees its slot one cycle later.
  assign can_issue_s = (32'(inflight_q) + 32'(cnt_q)) < 32'(FIFO_DEPTH);
  assign push_s      = core_valid_out_44;
  assign pop_s       = rsp_valid_q & rsp_ready_44;

  // Find the first valid requester at or after the round-robin pointer, with wrap.
  always_comb begin
    grant_idx_s = '0;
    any_valid_s = 1'b0;
    hit_s       = 1'b0;
    cand_s      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_s      = ID_W'((32'(rr_ptr_q) + 32'(k)) % 32'(N_REQ));
      hit_s       = !any_valid_s && req_valid_44[cand_s];
      grant_idx_s = hit_s ? cand_s : grant_idx_s;
      any_valid_s = any_valid_s | hit_s;
    end
  end

  // One-hot grant, suppressed while out of credit or held in reset.
  always_comb begin
    grant_s = '0;
    if (can_issue_s && any_valid_s && !rst_44) begin
      grant_s[grant_idx_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  assign hs_s = |(req_valid_44 & grant_s);

  // Operand mux for the granted requester.
  always_comb begin
    sel_a_s   = 16'h0000;
    sel_b_s   = 16'h0000;
    sel_sub_s = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      sel_a_s   = (grant_idx_s == ID_W'(k)) ? req_a_44[16*k +: 16] : sel_a_s;
      sel_b_s   = (grant_idx_s == ID_W'(k)) ? req_b_44[16*k +: 16] : sel_b_s;
      sel_sub_s = (grant_idx_s == ID_W'(k)) ? req_sub_44[k]        : sel_sub_s;
    end
  end

  // Next state of the issue register, pointer, tag pipeline, inflight counter and error flag.
  always_comb begin
    core_valid_d = hs_s;
    if (hs_s) begin
      core_a_d   = sel_a_s;
      core_b_d   = sel_b_s;
      core_sub_d = sel_sub_s;
      rr_ptr_d   = (grant_idx_s == LAST_ID) ? '0 : grant_idx_s + ID_W'(1);
    end else begin
      core_a_d   = core_a_q;
      core_b_d   = core_b_q;
      core_sub_d = core_sub_q;
      rr_ptr_d   = rr_ptr_q;
    end
    tag_v_d  = {tag_v_q[CORE_LAT-1:0], hs_s};
    tag_id_d = {tag_id_q[CORE_LAT-1:0], (hs_s ? grant_idx_s : {ID_W{1'b0}})};
    case ({hs_s, push_s})
      2'b10:   inflight_d = inflight_q + 3'd1;
      2'b01:   inflight_d = inflight_q - 3'd1;
      default: inflight_d = inflight_q;
    endcase
    err_d = err_q | (tag_v_q[CORE_LAT] ^ core_valid_out_44);
  end

  // Issue-side registers.
  always_ff @(posedge clk_44 or posedge rst_44) begin
    if (rst_44) begin
      rr_ptr_q     <= '0;
      core_valid_q <= 1'b0;
      core_a_q     <= 16'h0000;
      core_b_q     <= 16'h0000;
      core_sub_q   <= 1'b0;
      tag_v_q      <= '0;
      tag_id_q     <= '0;
      inflight_q   <= 3'd0;
      err_q        <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      core_valid_q <= core_valid_d;
      core_a_q     <= core_a_d;
      core_b_q     <= core_b_d;
      core_sub_q   <= core_sub_d;
      tag_v_q      <= tag_v_d;
      tag_id_q     <= tag_id_d;
      inflight_q   <= inflight_d;
      err_q        <= err_d;
    end
  end

  // FIFO pointer/count update and show-ahead head register (holds when empty).
  always_comb begin
    wr_ptr_d = push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    rsp_valid_d = (cnt_d != '0);
    if (rsp_valid_d && push_s && (rd_ptr_d == wr_ptr_q)) begin
      rsp_data_d = core_result_44;
      rsp_id_d   = tag_id_q[CORE_LAT];
    end else if (rsp_valid_d) begin
      rsp_data_d = mem_data_q[rd_ptr_d];
      rsp_id_d   = mem_id_q[rd_ptr_d];
    end else begin
      rsp_data_d = rsp_data_q;
      rsp_id_d   = rsp_id_q;
    end
  end

  // FIFO storage and response registers.
  always_ff @(posedge clk_44 or posedge rst_44) begin
    if (rst_44) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data_q[i] <= 16'h0000;
        mem_id_q[i]   <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 16'h0000;
      rsp_id_q    <= '0;
    end else begin
      if (push_s) begin
        mem_data_q[wr_ptr_q] <= core_result_44;
        mem_id_q[wr_ptr_q]   <= tag_id_q[CORE_LAT];
      end
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign req_ready_44     = grant_s;
  assign core_rst_n_44    = ~rst_44;
  assign core_valid_in_44 = core_valid_q;
  assign core_a_44        = core_a_q;
  assign core_b_44        = core_b_q;
  assign core_sub_44      = core_sub_q;
  assign rsp_valid_44     = rsp_valid_q;
  assign rsp_data_44      = rsp_data_q;
  assign rsp_id_44        = rsp_id_q;
  assign inflight_44      = inflight_q;
  assign err_44           = err_q;

endmodule
